// File: rtl/counter_pkg.sv
// Shared definitions for counter_mod: direction encoding and the
// WIDTH/MODULUS legality check used at elaboration.
package counter_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

  // True when the count range 0..modulus-1 fits a width-bit register.
  function automatic bit cfg_legal(input int unsigned width, input int unsigned modulus);
    if (width < 1 || width > 31) return 1'b0;
    return (modulus >= 32'd2) && (modulus <= (32'd1 << width));
  endfunction

endpackage

// File: rtl/counter_mod_if.sv
// Control/status bundle of counter_mod. The overflow signal exists only
// when COUNTER_MOD_STICKY_EN is defined.
interface counter_mod_if #(
  parameter int WIDTH = 4
);
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic             up_down;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
`ifdef COUNTER_MOD_STICKY_EN
  logic             overflow;
`endif

  modport master (
    output clear, load, load_value, enable, up_down,
    input  count, tc, wrap
`ifdef COUNTER_MOD_STICKY_EN
    , input overflow
`endif
  );

  modport slave (
    input  clear, load, load_value, enable, up_down,
    output count, tc, wrap
`ifdef COUNTER_MOD_STICKY_EN
    , output overflow
`endif
  );
endinterface

// File: rtl/counter_mod.sv
// Parametrised up/down modulo counter with clear, saturating load, terminal
// count and wrap pulse. COUNTER_MOD_STICKY_EN adds a sticky overflow flag.
module counter_mod
  import counter_pkg::*;
#(
  parameter int          WIDTH   = 4,
  parameter int unsigned MODULUS = 32'd1 << WIDTH
) (
  input  logic           clock,
  input  logic           reset_n,
  counter_mod_if.slave   bus
);

  if (!cfg_legal(WIDTH, MODULUS)) begin : g_bad_cfg
    $error("counter_mod: illegal WIDTH/MODULUS combination");
  end

  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MODULUS - 32'd1);
  localparam logic [WIDTH-1:0] MAX_CNT = MAX_EXT[WIDTH-1:0];

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH:0]   ld_ext;
  logic             at_max, at_zero;

  assign ld_ext  = {1'b0, bus.load_value};
  assign at_max  = (count_q == MAX_CNT);
  assign at_zero = (count_q == '0);

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (bus.clear) begin
      count_d = '0;
    end else if (bus.load) begin
      // Out-of-range load values saturate to the top of the count range.
      count_d = (ld_ext > MAX_EXT) ? MAX_CNT : bus.load_value;
    end else if (bus.enable) begin
      if (bus.up_down == CNT_UP) begin
        if (at_max) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          count_d = MAX_CNT;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;
  assign bus.tc    = bus.enable & ~bus.clear & ~bus.load &
                     (((bus.up_down == CNT_UP) & at_max) |
                      ((bus.up_down == CNT_DOWN) & at_zero));

`ifdef COUNTER_MOD_STICKY_EN
  logic ovf_q, ovf_d;

  // Load leaves the flag alone; only clear or reset drops it.
  always_comb begin
    ovf_d = ovf_q | wrap_d;
    if (bus.clear) ovf_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ovf_q <= 1'b0;
    else          ovf_q <= ovf_d;
  end

  assign bus.overflow = ovf_q;
`endif

endmodule

// File: tb/tb_counter_mod.sv
// Bench for counter_mod: WIDTH=4/MODULUS=10 vector table plus a
// WIDTH=3/MODULUS=8 natural-wrap instance; honours COUNTER_MOD_STICKY_EN.
module tb_counter_mod;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  counter_mod_if #(.WIDTH(4)) bus_a ();
  counter_mod_if #(.WIDTH(3)) bus_b ();

  counter_mod #(.WIDTH(4), .MODULUS(10)) dut_a (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus_a.slave)
  );

  counter_mod #(.WIDTH(3), .MODULUS(8)) dut_b (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus_b.slave)
  );

  typedef struct {
    logic       clr;
    logic       ld;
    logic [3:0] lv;
    logic       en;
    logic       ud;
    logic       etc;
    logic [3:0] ecnt;
    logic       ewrap;
    logic       eovf;
  } vec_t;

  typedef struct {
    string      nm;
    logic [3:0] cnt;
    logic       wrap;
    logic       ovf;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic clr, input logic ld, input logic [3:0] lv,
                              input logic en, input logic ud, input logic etc,
                              input logic [3:0] ecnt, input logic ewrap, input logic eovf);
    vec_t v;
    v.clr = clr; v.ld = ld; v.lv = lv; v.en = en; v.ud = ud;
    v.etc = etc; v.ecnt = ecnt; v.ewrap = ewrap; v.eovf = eovf;
    return v;
  endfunction

  function automatic logic ovf_a();
`ifdef COUNTER_MOD_STICKY_EN
    return bus_a.overflow;
`else
    return 1'b0;
`endif
  endfunction

  task automatic pop_check_a();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    chk({e.nm, "_count"}, 32'(bus_a.count), 32'(e.cnt));
    chk({e.nm, "_wrap"},  32'(bus_a.wrap),  32'(e.wrap));
`ifdef COUNTER_MOD_STICKY_EN
    chk({e.nm, "_ovf"},   32'(ovf_a()),     32'(e.ovf));
`endif
  endtask

  // Drive at negedge, check tc combinationally, check registered outputs after the edge.
  task automatic step_a(input string nm, input vec_t v);
    exp_t e;
    @(negedge clk);
    bus_a.clear = v.clr; bus_a.load = v.ld; bus_a.load_value = v.lv;
    bus_a.enable = v.en; bus_a.up_down = v.ud;
    #1;
    chk({nm, "_tc"}, 32'(bus_a.tc), 32'(v.etc));
    e.nm = nm; e.cnt = v.ecnt; e.wrap = v.ewrap; e.ovf = v.eovf;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    pop_check_a();
  endtask

  task automatic step_b(input string nm, input logic ud, input logic etc,
                        input logic [2:0] ecnt, input logic ewrap);
    @(negedge clk);
    bus_b.enable = 1'b1; bus_b.up_down = ud;
    #1;
    chk({nm, "_tc"}, 32'(bus_b.tc), 32'(etc));
    @(posedge clk);
    #1;
    chk({nm, "_count"}, 32'(bus_b.count), 32'(ecnt));
    chk({nm, "_wrap"},  32'(bus_b.wrap),  32'(ewrap));
  endtask

  initial begin
    bus_a.clear = 1'b0; bus_a.load = 1'b0; bus_a.load_value = '0;
    bus_a.enable = 1'b0; bus_a.up_down = 1'b1;
    bus_b.clear = 1'b0; bus_b.load = 1'b0; bus_b.load_value = '0;
    bus_b.enable = 1'b0; bus_b.up_down = 1'b1;

    // clr ld lv en ud | tc cnt wrap ovf
    for (int i = 1; i <= 9; i++) vecs.push_back(mk(0,0,0,1,1, 0,4'(i),0,0));
    vecs.push_back(mk(0,0,0,1,1, 1,0,1,1));   // 9 -> 0 wraps
    vecs.push_back(mk(0,0,0,1,1, 0,1,0,1));
    vecs.push_back(mk(0,0,0,1,1, 0,2,0,1));
    vecs.push_back(mk(1,0,0,1,1, 0,0,0,0));   // clear
    vecs.push_back(mk(0,0,0,1,0, 1,9,1,1));   // down from 0
    vecs.push_back(mk(0,0,0,1,0, 0,8,0,1));
    vecs.push_back(mk(0,0,0,1,0, 0,7,0,1));
    vecs.push_back(mk(0,1,13,1,0, 0,9,0,1));  // load saturates, ovf kept
    vecs.push_back(mk(1,1,5,0,1, 0,0,0,0));   // clear beats load
    vecs.push_back(mk(0,0,0,1,1, 0,1,0,0));   // enable toggling
    vecs.push_back(mk(0,0,0,0,1, 0,1,0,0));
    vecs.push_back(mk(0,0,0,1,1, 0,2,0,0));
    vecs.push_back(mk(0,0,0,0,1, 0,2,0,0));
    vecs.push_back(mk(0,0,0,1,1, 0,3,0,0));
    vecs.push_back(mk(0,0,0,0,1, 0,3,0,0));
    vecs.push_back(mk(0,1,9,0,1, 0,9,0,0));
    vecs.push_back(mk(0,0,0,1,1, 1,0,1,1));   // up wrap
    vecs.push_back(mk(0,0,0,1,0, 1,9,1,1));   // immediate down wrap
    vecs.push_back(mk(0,1,10,0,1, 0,9,0,1));  // load == MODULUS
    vecs.push_back(mk(0,1,3,1,1, 0,3,0,1));   // load masks tc and enable at 9
    vecs.push_back(mk(0,1,0,0,1, 0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,1));   // disabled at 0, down
    vecs.push_back(mk(1,0,0,1,0, 0,0,0,0));   // clear masks tc

    repeat (2) @(posedge clk);
    #1;
    chk("reset_count_a", 32'(bus_a.count), 32'd0);
    chk("reset_wrap_a",  32'(bus_a.wrap),  32'd0);
    chk("reset_ovf_a",   32'(ovf_a()),     32'd0);
    chk("reset_count_b", 32'(bus_b.count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) step_a($sformatf("row%0d", i), vecs[i]);

    // Asynchronous reset mid-count at 6.
    step_a("pre6_load", mk(0,1,5,0,1, 0,5,0,0));
    step_a("pre6_inc",  mk(0,0,0,1,1, 0,6,0,0));
    @(negedge clk);
    bus_a.enable = 1'b0; bus_a.load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(bus_a.count), 32'd0);
    chk("async_rst_wrap",  32'(bus_a.wrap),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset while the wrap pulse and overflow are high.
    step_a("prewrap_load", mk(0,1,9,0,1, 0,9,0,0));
    step_a("prewrap_inc",  mk(0,0,0,1,1, 1,0,1,1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst2_wrap", 32'(bus_a.wrap), 32'd0);
    chk("async_rst2_ovf",  32'(ovf_a()),    32'd0);
    chk("async_rst2_cnt",  32'(bus_a.count), 32'd0);
    @(negedge clk);
    bus_a.enable = 1'b0;
    rst_n = 1'b1;

    // WIDTH=3, MODULUS=8: natural binary wrap both ways.
    for (int i = 0; i < 8; i++)
      step_b($sformatf("b_up%0d", i), 1'b1, (i == 7), 3'(i + 1), (i == 7));
    step_b("b_down_wrap", 1'b0, 1'b1, 3'd7, 1'b1);
    step_b("b_down",      1'b0, 1'b0, 3'd6, 1'b0);
    @(negedge clk);
    bus_b.enable = 1'b0;

    if (sb_q.size() != 0) chk("scoreboard_leftover", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
